// File: rtl/count_seq_monitor.sv
// Sequence monitor for a mod-(MAX_COUNT+1) counter: locks on a 0, verifies every step,
// and reports verified periods, early restarts and illegal steps.
module count_seq_monitor #(
   parameter int CNT_W     = 4,
   parameter int MAX_COUNT = 10,
   parameter int WRAP_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [CNT_W-1:0]  count_in,
   output logic              locked,
   output logic              wrap_pulse,
   output logic              restart_pulse,
   output logic              err_pulse,
   output logic              err_sticky,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [7:0]        err_cnt
);

   localparam logic [0:0]       SEARCH = 1'b0;
   localparam logic [0:0]       TRACK  = 1'b1;
   localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_COUNT);
   localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

   logic [0:0]        state_r, state_s;
   logic [CNT_W-1:0]  expected_r, expected_s;
   logic              wrap_s, restart_s, err_s, sticky_s;
   logic [WRAP_W-1:0] wrap_cnt_s;
   logic [7:0]        err_cnt_s;

   // Next-state and next-output computation; clear overrides the tracking logic.
   always_comb begin
      state_s    = state_r;
      expected_s = expected_r;
      wrap_s     = 1'b0;
      restart_s  = 1'b0;
      err_s      = 1'b0;
      sticky_s   = err_sticky;
      wrap_cnt_s = wrap_cnt;
      err_cnt_s  = err_cnt;
      if (clear) begin
         state_s    = SEARCH;
         expected_s = ZERO_V;
         sticky_s   = 1'b0;
         wrap_cnt_s = {WRAP_W{1'b0}};
         err_cnt_s  = 8'd0;
      end else begin
         case (state_r)
            SEARCH: begin
               if (count_in == ZERO_V) begin
                  state_s    = TRACK;
                  expected_s = ONE_V;
               end else begin
                  state_s    = SEARCH;
               end
            end
            TRACK: begin
               if (count_in == expected_r) begin
                  if (expected_r == MAX_V) begin
                     expected_s = ZERO_V;
                     wrap_s     = 1'b1;
                     wrap_cnt_s = wrap_cnt + WRAP_W'(1);
                  end else begin
                     expected_s = expected_r + ONE_V;
                  end
               end else if (count_in == ZERO_V) begin
                  // Zero while expecting non-zero: the upstream counter was resynced.
                  restart_s  = 1'b1;
                  expected_s = ONE_V;
               end else begin
                  err_s      = 1'b1;
                  sticky_s   = 1'b1;
                  state_s    = SEARCH;
                  expected_s = ZERO_V;
                  if (err_cnt != 8'd255) begin
                     err_cnt_s = err_cnt + 8'd1;
                  end else begin
                     err_cnt_s = err_cnt;
                  end
               end
            end
            default: begin
               state_s    = SEARCH;
               expected_s = ZERO_V;
            end
         endcase
      end
   end

   // State, expected value and all status outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= SEARCH;
         expected_r    <= ZERO_V;
         wrap_pulse    <= 1'b0;
         restart_pulse <= 1'b0;
         err_pulse     <= 1'b0;
         err_sticky    <= 1'b0;
         wrap_cnt      <= {WRAP_W{1'b0}};
         err_cnt       <= 8'd0;
      end else begin
         state_r       <= state_s;
         expected_r    <= expected_s;
         wrap_pulse    <= wrap_s;
         restart_pulse <= restart_s;
         err_pulse     <= err_s;
         err_sticky    <= sticky_s;
         wrap_cnt      <= wrap_cnt_s;
         err_cnt       <= err_cnt_s;
      end
   end

   assign locked = (state_r == TRACK);

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream consumer of the mod-(MAX_COUNT+1) counter stage; samples its 4-bit count output every clock.
- Locks onto the 0..MAX_COUNT sequence and verifies every step, flagging illegal steps.
- Reports completed periods, early restarts and errors for scoreboarding and status registers.

Parameters:
CNT_W, 4, width of sampled count bus
MAX_COUNT, 10, terminal value of upstream counter; legal sequence 0,1,...,MAX_COUNT,0
WRAP_W, 8, width of completed-period counter

Ports:
clk  input  1  rising-edge clock, same clock as upstream counter
reset  input  1  asynchronous, active-low reset (0 = reset)
clear  input  1  synchronous resync/clear, active-high
count_in  input  CNT_W  count value from upstream counter
locked  output  1  high while tracking a verified sequence
wrap_pulse  output  1  one-cycle pulse: a full period ending at MAX_COUNT was verified
restart_pulse  output  1  one-cycle pulse: count_in returned to 0 before MAX_COUNT while locked
err_pulse  output  1  one-cycle pulse: illegal step detected
err_sticky  output  1  set on any error; cleared only by reset or clear
wrap_cnt  output  WRAP_W  number of verified periods, modulo 2^WRAP_W
err_cnt  output  8  number of errors, saturating at 255

Behaviour:
- Reset (reset=0, async): state=SEARCH, expected=0; locked, wrap_pulse, restart_pulse, err_pulse, err_sticky = 0; wrap_cnt=0, err_cnt=0.
- All outputs registered; an event sampled at edge N appears after edge N and holds for one cycle (pulses) or until changed.
- Priority per edge: clear > state-machine update. clear=1 → state=SEARCH, all outputs/counters cleared, as at reset.
- State SEARCH (locked=0):
  - count_in==0 → TRACK, expected=1, locked=1.
  - Any other value (including >MAX_COUNT) → stay SEARCH; no error, no counters change.
- State TRACK (locked=1). Conditions are checked in order; the first match applies:
  - count_in==expected:
    - expected = (expected==MAX_COUNT) ? 0 : expected+1.
    - If count_in==MAX_COUNT: wrap_pulse=1, wrap_cnt+=1 (wraps to 0 past 2^WRAP_W-1).
  - count_in==0 and expected!=0 (upstream sync reset mid-period): restart_pulse=1, expected=1, stay TRACK, no error.
  - Otherwise (skip, repeat, backward step, or value >MAX_COUNT): err_pulse=1, err_sticky=1, err_cnt+=1 unless already 255; state=SEARCH, locked=0.
- An error sample that is itself 0 cannot occur: the restart rule covers it. The next 0 after an error relocks via SEARCH.
- Repeated 0 while expected==1 counts as a restart, not an error.
- Async reset asserted mid-period drops everything immediately. After release, the monitor needs a 0 to relock.
- The arithmetic on expected is CNT_W bits wide and never exceeds MAX_COUNT. MAX_COUNT must be < 2^CNT_W.

Test Plan:
- Reset low 3 cycles, release, drive 0,1..10,0,1..10 → locked=1 after first 0; wrap_pulse twice (after each 10 sample); wrap_cnt=2; err_cnt=0.
- Locked, drive 0..4 then 6 → err_pulse one cycle after 6 sampled; err_sticky=1; err_cnt=1; locked=0; then 7,8 (no further errors); then 0 → relock.
- Locked, drive 0..5 then 0,1,2 → restart_pulse one cycle, no error, locked stays 1, wrap_cnt unchanged.
- Drive 12 (>MAX) while locked → error, err_cnt increments. Drive 12 while in SEARCH → no error.
- Force 300 illegal steps, each followed by a 0 to relock → err_cnt=255 (saturated). Run 256 clean periods → wrap_cnt wraps to 0.
- Assert reset low mid-period at count 7 → all outputs 0 immediately (asynchronously). Pulse clear during TRACK → same cleared state at the next edge; err_sticky=0.
